trigger_sequencer: RTL and testbench

// Schedules shared trigger-channel resources between NUM_REQ requesters (SW, ext pin, periodic timer).

---
 rtl/trigger_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/trigger_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_trigger_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Shared types for the trigger sequencer: channel trigger states, sequencer
// states and the trigger pulse length.
package trigger_pkg;

  typedef enum logic [2:0] {
    CH_IDLE   = 3'd0,
    CH_EDGE   = 3'd1,
    CH_PHASE  = 3'd2,
    CH_ADJUST = 3'd3
  } ch_state_e;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_ARB      = 3'd1,
    SEQ_ARM      = 3'd2,
    SEQ_FIRE     = 3'd3,
    SEQ_WAIT_ADJ = 3'd4,
    SEQ_HOLDOFF  = 3'd5
  } seq_state_e;

  // Channel edge detectors are registered, so the pulse must span two cycles.
  localparam int TRIG_PULSE_LEN = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around, plus a flag saying whether any request was found.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     grant,
  output logic               valid
);

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[IDW'(idx)]) begin
        grant = IDW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Arbitrates trigger requests round-robin, arms the requested channel subset,
// fires one trigger pulse, waits for phase adjust to finish, then holds off and acks.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_CH  = 4,
  parameter int TMO_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_CH-1:0]    req_mask,
  input  logic                         bsync_ready,
  input  logic [TMO_W-1:0]             holdoff,
  input  logic [TMO_W-1:0]             timeout,
  input  logic [3*NUM_CH-1:0]          ch_state,
  output logic [NUM_CH-1:0]            ch_en,
  output logic                         trigger,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         err,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = (TRIG_PULSE_LEN > 1) ? $clog2(TRIG_PULSE_LEN) : 1;

  localparam logic [2:0] ST_IDLE     = SEQ_IDLE;
  localparam logic [2:0] ST_ARB      = SEQ_ARB;
  localparam logic [2:0] ST_ARM      = SEQ_ARM;
  localparam logic [2:0] ST_FIRE     = SEQ_FIRE;
  localparam logic [2:0] ST_WAIT_ADJ = SEQ_WAIT_ADJ;
  localparam logic [2:0] ST_HOLDOFF  = SEQ_HOLDOFF;

  logic [2:0]         state_reg;
  logic [NUM_CH-1:0]  mask_reg;
  logic [IDW-1:0]     grant_reg;
  logic [IDW-1:0]     rr_ptr_reg;
  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic [TMO_W-1:0]   hold_cnt_reg;
  logic [PW-1:0]      pulse_cnt_reg;
  logic               seen_reg;
  logic [NUM_REQ-1:0] ack_reg;
  logic               err_reg;

  logic [IDW-1:0]     arb_grant;
  logic               arb_valid;
  logic [IDW-1:0]     ptr_next;
  logic [NUM_CH-1:0]  sel_mask;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_CH-1:0]  ch_is_edge;
  logic [NUM_CH-1:0]  ch_is_adj;
  logic               all_edge;
  logic               any_adjust;
  logic [TMO_W-1:0]   tmo_inc;
  logic               tmo_hit;
  logic [TMO_W-1:0]   hold_inc;
  logic               ch_active;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr_reg),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_is_edge[gi] = (ch_state[gi*3 +: 3] == CH_EDGE);
    assign ch_is_adj[gi]  = (ch_state[gi*3 +: 3] == CH_ADJUST);
  end

  // Unmasked channels never hold up or advance the sequence.
  assign all_edge   = &(ch_is_edge | ~mask_reg);
  assign any_adjust = |(ch_is_adj & mask_reg);

  assign sel_mask     = req_mask[arb_grant*NUM_CH +: NUM_CH];
  assign ptr_next     = (arb_grant == IDW'(NUM_REQ - 1)) ? '0 : arb_grant + 1'b1;
  assign arb_onehot   = NUM_REQ'(1) << arb_grant;
  assign grant_onehot = NUM_REQ'(1) << grant_reg;

  assign tmo_inc  = tmo_cnt_reg + 1'b1;
  assign tmo_hit  = (timeout != '0) && (tmo_inc == timeout);
  assign hold_inc = hold_cnt_reg + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      mask_reg      <= '0;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      tmo_cnt_reg   <= '0;
      hold_cnt_reg  <= '0;
      pulse_cnt_reg <= '0;
      seen_reg      <= 1'b0;
      ack_reg       <= '0;
      err_reg       <= 1'b0;
    end else begin
      ack_reg <= '0;
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|req) state_reg <= ST_ARB;
        end
        ST_ARB: begin
          if (!arb_valid) begin
            state_reg <= ST_IDLE;
          end else begin
            grant_reg  <= arb_grant;
            mask_reg   <= sel_mask;
            rr_ptr_reg <= ptr_next;
            if (sel_mask == '0) begin
              ack_reg   <= arb_onehot;
              err_reg   <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              tmo_cnt_reg <= '0;
              state_reg   <= ST_ARM;
            end
          end
        end
        ST_ARM: begin
          if (bsync_ready && all_edge) begin
            pulse_cnt_reg <= '0;
            state_reg     <= ST_FIRE;
          end else if (tmo_hit) begin
            ack_reg   <= grant_onehot;
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_inc;
          end
        end
        ST_FIRE: begin
          if (pulse_cnt_reg == PW'(TRIG_PULSE_LEN - 1)) begin
            tmo_cnt_reg <= '0;
            seen_reg    <= 1'b0;
            state_reg   <= ST_WAIT_ADJ;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
          end
        end
        ST_WAIT_ADJ: begin
          // The completion cycle counts as the first holdoff cycle.
          if (seen_reg && all_edge) begin
            if (holdoff <= TMO_W'(1)) begin
              ack_reg   <= grant_onehot;
              state_reg <= ST_IDLE;
            end else begin
              hold_cnt_reg <= TMO_W'(1);
              state_reg    <= ST_HOLDOFF;
            end
          end else if (tmo_hit) begin
            ack_reg   <= grant_onehot;
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_inc;
            if (any_adjust) seen_reg <= 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (hold_inc >= holdoff) begin
            ack_reg   <= grant_onehot;
            state_reg <= ST_IDLE;
          end else begin
            hold_cnt_reg <= hold_inc;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Decoded from state so enables and trigger drop with reset and on every exit.
  assign ch_active = (state_reg == ST_ARM) || (state_reg == ST_FIRE) ||
                     (state_reg == ST_WAIT_ADJ) || (state_reg == ST_HOLDOFF);
  assign ch_en     = ch_active ? mask_reg : '0;
  assign trigger   = (state_reg == ST_FIRE);
  assign busy      = (state_reg != ST_IDLE);
  assign ack       = ack_reg;
  assign err       = err_reg;
  assign grant_id  = grant_reg;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Scoreboard bench for trigger_sequencer: directed scenarios push expected
// acks; a monitor pops and checks every ack/err the DUT presents.
module tb_trigger_sequencer;

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_EDGE  = 3'd1;
  localparam logic [2:0] C_PHASE = 3'd2;
  localparam logic [2:0] C_ADJ   = 3'd3;

  typedef struct {
    logic [3:0] ack;
    logic       err;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_mask;
  logic        bsync_ready;
  logic [15:0] holdoff;
  logic [15:0] timeout;
  logic [11:0] ch_state;
  logic [11:0] man_ch;
  logic [11:0] model_ch;
  logic        model_en;
  logic [3:0]  ch_en;
  logic        trigger;
  logic [3:0]  ack;
  logic        err;
  logic [1:0]  grant_id;
  logic        busy;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   trig_n;
  int   trig_first;
  logic [3:0] ch_acc;
  int   mcnt = 0;

  trigger_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_mask    (req_mask),
    .bsync_ready (bsync_ready),
    .holdoff     (holdoff),
    .timeout     (timeout),
    .ch_state    (ch_state),
    .ch_en       (ch_en),
    .trigger     (trigger),
    .ack         (ack),
    .err         (err),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ch_state = model_en ? model_ch : man_ch;

  // Ideal channels: go ADJUST on trigger, back to EDGE three cycles later.
  always @(negedge clk) begin
    if (!model_en) begin
      model_ch = {4{C_EDGE}};
      mcnt = 0;
    end else if (trigger) begin
      model_ch = {4{C_ADJ}};
      mcnt = 3;
    end else if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) model_ch = {4{C_EDGE}};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (trigger) begin
      trig_n++;
      if (trig_first < 0) trig_first = cyc;
    end
    ch_acc = ch_acc | ch_en;
  endtask

  task automatic clear_obs();
    trig_n = 0;
    trig_first = -1;
    ch_acc = 4'b0;
  endtask

  task automatic wait_ack(input int bound, input string name);
    int t;
    t = 0;
    do begin
      step();
      t++;
    end while (ack == 4'b0 && t < bound);
    if (ack == 4'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no ack within %0d cycles, required one", name, bound);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (ack != 4'b0 || err)) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack=%b err=%b required none (cycle %0d)", ack, err, cyc);
        end else begin
          e = sb.pop_front();
          $display("ack txn: ack=%b err=%b grant_id=%0d cycle=%0d", ack, err, grant_id, cyc);
          chk("ack_vec", 32'(ack), 32'(e.ack));
          chk("ack_err", 32'(err), 32'(e.err));
          if (e.cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          chk("ch_en_at_ack", 32'(ch_en), 32'(0));
          chk("trigger_at_ack", 32'(trigger), 32'(0));
        end
      end
    end
  endtask

  task automatic run_tests();
    int r;
    // Reset state
    rst = 1'b1; req = 4'b0; req_mask = 16'h0; bsync_ready = 1'b0;
    holdoff = 16'd0; timeout = 16'd0; man_ch = {4{C_IDLE}}; model_en = 1'b0;
    clear_obs();
    repeat (3) step();
    chk("rst_ch_en", 32'(ch_en), 32'(0));
    chk("rst_trigger", 32'(trigger), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_grant_id", 32'(grant_id), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    repeat (2) step();

    // Round robin with all requests held: grants 0,1,2,3,0
    req_mask = {4'b1111, 4'b0110, 4'b0011, 4'b0001};
    bsync_ready = 1'b1; holdoff = 16'd2; model_en = 1'b1;
    sb.push_back('{4'b0001, 1'b0, -1});
    sb.push_back('{4'b0010, 1'b0, -1});
    sb.push_back('{4'b0100, 1'b0, -1});
    sb.push_back('{4'b1000, 1'b0, -1});
    sb.push_back('{4'b0001, 1'b0, -1});
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_ack(200, "rr_ack");
    req = 4'b0;
    repeat (4) step();
    model_en = 1'b0;
    repeat (2) step();

    // Single request with holdoff 5
    req_mask = {4'b1111, 4'b0000, 4'b0011, 4'b0011};
    man_ch = {C_IDLE, C_IDLE, C_EDGE, C_EDGE};
    holdoff = 16'd5; timeout = 16'd0;
    clear_obs();
    r = cyc;
    req = 4'b0001;
    repeat (6) step();
    chk("t1_trig_first", 32'(trig_first), 32'(r + 3));
    chk("t1_trig_len", 32'(trig_n), 32'(2));
    chk("t1_ch_en", 32'(ch_en), 32'(4'b0011));
    chk("t1_busy", 32'(busy), 32'(1));
    man_ch = {C_IDLE, C_IDLE, C_ADJ, C_ADJ};
    repeat (2) step();
    man_ch = {C_IDLE, C_IDLE, C_EDGE, C_EDGE};
    sb.push_back('{4'b0001, 1'b0, cyc + 5});
    wait_ack(20, "t1_ack");
    req = 4'b0;
    repeat (3) step();
    chk("t1_trig_total", 32'(trig_n), 32'(2));
    chk("t1_ch_en_after", 32'(ch_en), 32'(0));

    // Zero mask: immediate error ack, nothing enabled or fired
    clear_obs();
    r = cyc;
    req = 4'b0100;
    sb.push_back('{4'b0100, 1'b1, r + 2});
    wait_ack(10, "t3_ack");
    chk("t3_grant_id", 32'(grant_id), 32'(2));
    req = 4'b0;
    repeat (3) step();
    chk("t3_no_trigger", 32'(trig_n), 32'(0));
    chk("t3_ch_en_never", 32'(ch_acc), 32'(0));

    // ARM timeout: ch1 stuck at PHASE
    man_ch = {C_IDLE, C_IDLE, C_PHASE, C_EDGE};
    timeout = 16'd20;
    clear_obs();
    r = cyc;
    req = 4'b0010;
    sb.push_back('{4'b0010, 1'b1, r + 22});
    repeat (10) step();
    chk("t4_ch_en_arm", 32'(ch_en), 32'(4'b0011));
    chk("t4_grant_id", 32'(grant_id), 32'(1));
    wait_ack(30, "t4_ack");
    req = 4'b0;
    repeat (2) step();
    chk("t4_no_trigger", 32'(trig_n), 32'(0));

    // No ADJUST after fire, timeout disabled: stays busy forever
    man_ch = {C_IDLE, C_IDLE, C_EDGE, C_EDGE};
    timeout = 16'd0;
    clear_obs();
    req = 4'b0001;
    repeat (60) step();
    chk("t5_busy", 32'(busy), 32'(1));
    chk("t5_ch_en", 32'(ch_en), 32'(4'b0011));
    chk("t5_trig_len", 32'(trig_n), 32'(2));
    chk("t5_trigger_low", 32'(trigger), 32'(0));

    // Asynchronous reset mid WAIT_ADJ
    #2 rst = 1'b1;
    #1;
    chk("t6_ch_en_async", 32'(ch_en), 32'(0));
    chk("t6_busy_async", 32'(busy), 32'(0));
    chk("t6_grant_async", 32'(grant_id), 32'(0));
    req = 4'b0;
    repeat (2) step();
    rst = 1'b0;
    holdoff = 16'd0;
    model_en = 1'b1;
    step();
    req = 4'b1001;
    sb.push_back('{4'b0001, 1'b0, -1});
    wait_ack(50, "t6_ack");
    chk("t6_grant_after_rst", 32'(grant_id), 32'(0));
    req = 4'b0;
    repeat (5) step();
    chk("t6_idle", 32'(busy), 32'(0));
    chk("sb_drained", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    fork
      monitor();
      run_tests();
      begin
        #200000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
